// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Purpose:
//   Single-outstanding load/store responder backed by local byte-addressable
//   storage (2^ADDR_WIDTH bytes, little-endian, organised as 32-bit words split
//   into four byte lanes). A request is accepted in IDLE, optionally held for
//   WAIT_CYCLES cycles, then answered with a one-cycle response strobe. Loads
//   return lane-selected data extended to 32 bits; misaligned, illegal-size or
//   out-of-range requests return an error and never touch storage.
//
// Parameters:
//   ADDR_WIDTH   byte-address bits of local storage (default 12)
//   WAIT_CYCLES  extra response latency in cycles, 0..15 (default 1)
//
// Ports:
//   clk             sole clock, rising edge
//   rst_n           asynchronous active-low reset
//   req_valid_i     request present
//   req_ready_o     responder idle and able to accept
//   req_we_i        1 = store, 0 = load
//   req_size_i      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned_i  1 = zero-extend load data, 0 = sign-extend
//   req_addr_i      byte address
//   req_wdata_i     right-aligned store data
//   resp_valid_o    one-cycle response strobe
//   resp_rdata_o    extended load data (0 for stores, errors, and when idle)
//   resp_err_o      request rejected (only meaningful with resp_valid_o)
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);

  localparam int         IDX_W     = ADDR_WIDTH - 2;
  localparam int         DEPTH     = 2 ** IDX_W;
  localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        resp_valid_q;
  logic        resp_err_q;

  // The request being committed: straight from the inputs when the commit
  // happens on the accept edge (WAIT_CYCLES = 0), otherwise the captured copy.
  logic        cur_we;
  logic [1:0]  cur_size;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        cur_err;
  logic        enter_resp;
  logic        do_write;
  logic [3:0]  byte_en;
  logic [31:0] wlane_data;
  logic [IDX_W-1:0] word_idx;
  logic [31:0] rd_word;
  logic [31:0] rd_shift;
  logic [31:0] load_data;

  assign req_ready_o = (state_q == ST_IDLE);

  always_comb begin
    cur_we    = we_q;
    cur_size  = size_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (state_q == ST_IDLE) begin
      cur_we    = req_we_i;
      cur_size  = req_size_i;
      cur_addr  = req_addr_i;
      cur_wdata = req_wdata_i;
    end
  end

  always_comb begin
    cur_err = 1'b0;
    if (cur_size == 2'b11) cur_err = 1'b1;
    if (cur_size == 2'b01 && cur_addr[0]) cur_err = 1'b1;
    if (cur_size == 2'b10 && cur_addr[1:0] != 2'b00) cur_err = 1'b1;
    if ((cur_addr >> ADDR_WIDTH) != 32'd0) cur_err = 1'b1;
  end

  // rst_n gates the commit so that nothing reaches storage while reset is
  // held, even if a request is presented to the (forced) IDLE state.
  assign enter_resp = rst_n &&
                      (((state_q == ST_IDLE) && req_valid_i && NO_WAIT) ||
                       ((state_q == ST_WAIT) && (cnt_q == 4'd0)));
  assign do_write   = enter_resp && cur_we && !cur_err;
  assign word_idx   = cur_addr[ADDR_WIDTH-1:2];

  // Byte enables and lane-replicated write data for the addressed lanes.
  always_comb begin
    byte_en    = 4'b0000;
    wlane_data = cur_wdata;
    case (cur_size)
      2'b00: begin
        byte_en    = 4'b0001 << cur_addr[1:0];
        wlane_data = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        byte_en    = cur_addr[1] ? 4'b1100 : 4'b0011;
        wlane_data = {2{cur_wdata[15:0]}};
      end
      2'b10: begin
        byte_en    = 4'b1111;
        wlane_data = cur_wdata;
      end
      default: begin
        byte_en    = 4'b0000;
        wlane_data = cur_wdata;
      end
    endcase
  end

  // One block-RAM-style byte array per lane; read is registered on the
  // commit edge so the word is ready while the response is presented.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem_lane [DEPTH];
      logic [7:0] rd_lane_q;

      always_ff @(posedge clk) begin
        if (do_write && byte_en[gi]) begin
          mem_lane[word_idx] <= wlane_data[8*gi +: 8];
        end
        if (enter_resp) begin
          rd_lane_q <= mem_lane[word_idx];
        end
      end

      assign rd_word[8*gi +: 8] = rd_lane_q;
    end
  endgenerate

  // Control FSM; response strobe and error flag are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            we_q    <= req_we_i;
            size_q  <= req_size_i;
            uns_q   <= req_unsigned_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            if (NO_WAIT) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= cur_err;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= WAIT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= cur_err;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
        end
        default: begin
          state_q      <= ST_IDLE;
          cnt_q        <= 4'd0;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
        end
      endcase
    end
  end

  // Lane select and extension of the registered read word. Word accesses are
  // aligned, so the shift is zero for them.
  assign rd_shift = rd_word >> {addr_q[1:0], 3'b000};

  always_comb begin
    case (size_q)
      2'b00:   load_data = uns_q ? {24'd0, rd_shift[7:0]}
                                 : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_data = uns_q ? {16'd0, rd_shift[15:0]}
                                 : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: load_data = rd_word;
    endcase
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_valid_q && resp_err_q;
  assign resp_rdata_o = (resp_valid_q && !resp_err_q && !we_q) ? load_data : 32'd0;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic        clk;
  logic        rst_n;

  // Main instance, WAIT_CYCLES = 1
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_uns;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  // Second instance, WAIT_CYCLES = 0
  logic        req_valid0;
  logic        req_ready0;
  logic        req_we0;
  logic [1:0]  req_size0;
  logic        req_uns0;
  logic [31:0] req_addr0;
  logic [31:0] req_wdata0;
  logic        resp_valid0;
  logic [31:0] resp_rdata0;
  logic        resp_err0;

  int checks;
  int errors;

  data_mem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_uns),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .resp_valid_o   (resp_valid),
    .resp_rdata_o   (resp_rdata),
    .resp_err_o     (resp_err)
  );

  data_mem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) dut0 (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid0),
    .req_ready_o    (req_ready0),
    .req_we_i       (req_we0),
    .req_size_i     (req_size0),
    .req_unsigned_i (req_uns0),
    .req_addr_i     (req_addr0),
    .req_wdata_i    (req_wdata0),
    .resp_valid_o   (resp_valid0),
    .resp_rdata_o   (resp_rdata0),
    .resp_err_o     (resp_err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // One request on the main instance; returns data, error and latency
  // (edges from the accept edge, inclusive, until resp_valid is seen).
  task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic err, output int lat);
    int guard;
    rd  = 32'd0;
    err = 1'b0;
    lat = -1;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_we    = we;
    req_size  = sz;
    req_uns   = uns;
    req_addr  = addr;
    req_wdata = wdata;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 20) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 required=1");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("ready_busy", {31'd0, req_ready}, 32'd0);
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout actual=0 required=1");
      return;
    end
    rd  = resp_rdata;
    err = resp_err;
    @(posedge clk); #1;
    chk("strobe_once", {31'd0, resp_valid}, 32'd0);
    chk("ready_back", {31'd0, req_ready}, 32'd1);
    chk("rdata_idle_zero", resp_rdata, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          accepts;
    int          resps;

    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    req_valid = 0; req_we = 0; req_size = 0; req_uns = 0; req_addr = 0; req_wdata = 0;
    req_valid0 = 0; req_we0 = 0; req_size0 = 0; req_uns0 = 0; req_addr0 = 0; req_wdata0 = 0;

    // name, we, size, uns, addr, wdata, exp_rdata, exp_err
    vq.push_back('{"sw_100",      1'b1, 2'b10, 1'b0, 32'h100,      32'hDEADBEEF, 32'h0,        1'b0});
    vq.push_back('{"lw_100",      1'b0, 2'b10, 1'b0, 32'h100,      32'h0,        32'hDEADBEEF, 1'b0});
    vq.push_back('{"sb_102",      1'b1, 2'b00, 1'b0, 32'h102,      32'hFFFFFF5A, 32'h0,        1'b0});
    vq.push_back('{"lb_103",      1'b0, 2'b00, 1'b0, 32'h103,      32'h0,        32'hFFFFFFDE, 1'b0});
    vq.push_back('{"lhu_102",     1'b0, 2'b01, 1'b1, 32'h102,      32'h0,        32'h0000DE5A, 1'b0});
    vq.push_back('{"lw_100b",     1'b0, 2'b10, 1'b0, 32'h100,      32'h0,        32'hDE5ABEEF, 1'b0});
    vq.push_back('{"lh_100",      1'b0, 2'b01, 1'b0, 32'h100,      32'h0,        32'hFFFFBEEF, 1'b0});
    vq.push_back('{"lbu_101",     1'b0, 2'b00, 1'b1, 32'h101,      32'h0,        32'h000000BE, 1'b0});
    vq.push_back('{"lb_102",      1'b0, 2'b00, 1'b0, 32'h102,      32'h0,        32'h0000005A, 1'b0});
    vq.push_back('{"lw_102_err",  1'b0, 2'b10, 1'b0, 32'h102,      32'h0,        32'h0,        1'b1});
    vq.push_back('{"sh_101_err",  1'b1, 2'b01, 1'b0, 32'h101,      32'h1111,     32'h0,        1'b1});
    vq.push_back('{"sz3_0_err",   1'b0, 2'b11, 1'b0, 32'h0,        32'h0,        32'h0,        1'b1});
    vq.push_back('{"lw_1000_err", 1'b0, 2'b10, 1'b0, 32'h1000,     32'h0,        32'h0,        1'b1});
    vq.push_back('{"sb_hi_err",   1'b1, 2'b00, 1'b0, 32'h80000100, 32'h77,       32'h0,        1'b1});
    vq.push_back('{"lw_100c",     1'b0, 2'b10, 1'b0, 32'h100,      32'h0,        32'hDE5ABEEF, 1'b0});
    vq.push_back('{"sw_200",      1'b1, 2'b10, 1'b0, 32'h200,      32'hCAFEF00D, 32'h0,        1'b0});
    vq.push_back('{"sh_202",      1'b1, 2'b01, 1'b0, 32'h202,      32'hAAAA1234, 32'h0,        1'b0});
    vq.push_back('{"lw_200",      1'b0, 2'b10, 1'b0, 32'h200,      32'h0,        32'h1234F00D, 1'b0});
    vq.push_back('{"lwu_200",     1'b0, 2'b10, 1'b1, 32'h200,      32'h0,        32'h1234F00D, 1'b0});

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    chk("rst_ready0", {31'd0, req_ready0}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven transactions
    foreach (vq[i]) begin
      run_req(vq[i].we, vq[i].size, vq[i].uns, vq[i].addr, vq[i].wdata, rd, err, lat);
      $display("txn %s addr=%h rdata=%h err=%0d lat=%0d", vq[i].name, vq[i].addr, rd, err, lat);
      chk({vq[i].name, "_rdata"}, rd, vq[i].exp_rdata);
      chk({vq[i].name, "_err"}, {31'd0, err}, {31'd0, vq[i].exp_err});
      chk({vq[i].name, "_lat"}, lat, 32'd2);
    end

    // Continuous request: ready once per 3 cycles, one response per accept
    accepts = 0;
    resps   = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_uns = 1'b0;
    req_addr = 32'h100; req_wdata = 32'h0;
    for (int i = 0; i < 12; i++) begin
      chk("hold_ready", {31'd0, req_ready}, (i % 3 == 0) ? 32'd1 : 32'd0);
      if (req_ready) accepts++;
      if (resp_valid) begin
        resps++;
        chk("hold_rdata", resp_rdata, 32'hDE5ABEEF);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid) resps++;
      @(posedge clk); #1;
    end
    $display("txn hold accepts=%0d resps=%0d", accepts, resps);
    chk("hold_accepts", accepts, 32'd4);
    chk("hold_resps", resps, 32'd4);

    // Reset while a store waits: no commit, outputs cleared at once
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_uns = 1'b0;
    req_addr = 32'h200; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rstw_in_wait", {31'd0, req_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstw_valid", {31'd0, resp_valid}, 32'd0);
    chk("rstw_rdata", resp_rdata, 32'd0);
    chk("rstw_err", {31'd0, resp_err}, 32'd0);
    chk("rstw_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    chk("rstw_held_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, rd, err, lat);
    $display("txn lw_200_after_reset rdata=%h err=%0d lat=%0d", rd, err, lat);
    chk("rstw_load", rd, 32'h1234F00D);
    chk("rstw_load_err", {31'd0, err}, 32'd0);

    // Zero-wait instance: response the cycle after accept
    @(posedge clk); #1;
    req_valid0 = 1'b1; req_we0 = 1'b1; req_size0 = 2'b10; req_uns0 = 1'b0;
    req_addr0 = 32'h10; req_wdata0 = 32'hA5C3961E;
    chk("w0_ready_pre", {31'd0, req_ready0}, 32'd1);
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    chk("w0_st_valid", {31'd0, resp_valid0}, 32'd1);
    chk("w0_st_ready", {31'd0, req_ready0}, 32'd0);
    chk("w0_st_rdata", resp_rdata0, 32'd0);
    @(posedge clk); #1;
    chk("w0_st_valid_off", {31'd0, resp_valid0}, 32'd0);
    chk("w0_st_ready_back", {31'd0, req_ready0}, 32'd1);
    $display("txn w0_sw_10 wdata=a5c3961e");
    req_valid0 = 1'b1; req_we0 = 1'b0; req_size0 = 2'b00; req_uns0 = 1'b0;
    req_addr0 = 32'h11;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    chk("w0_lb_valid", {31'd0, resp_valid0}, 32'd1);
    chk("w0_lb_rdata", resp_rdata0, 32'hFFFFFF96);
    chk("w0_lb_err", {31'd0, resp_err0}, 32'd0);
    $display("txn w0_lb_11 rdata=%h", resp_rdata0);
    @(posedge clk); #1;
    chk("w0_lb_ready_back", {31'd0, req_ready0}, 32'd1);
    req_valid0 = 1'b1; req_we0 = 1'b0; req_size0 = 2'b10; req_addr0 = 32'h12;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    chk("w0_err_valid", {31'd0, resp_valid0}, 32'd1);
    chk("w0_err_flag", {31'd0, resp_err0}, 32'd1);
    chk("w0_err_rdata", resp_rdata0, 32'd0);
    $display("txn w0_lw_12 err=%0d", resp_err0);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, byte-address bits of local storage (2^ADDR_WIDTH bytes).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, extra response latency in cycles, legal range 0..15.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid_i  input  1  load/store request present.
REQ-006 req_ready_o  output  1  responder can accept a request this cycle.
REQ-007 req_we_i  input  1  1 = store, 0 = load.
REQ-008 req_size_i  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 req_unsigned_i  input  1  1 = zero-extend load data, 0 = sign-extend.
REQ-010 req_addr_i  input  32  byte address.
REQ-011 req_wdata_i  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 resp_valid_o  output  1  one-cycle response strobe.
REQ-013 resp_rdata_o  output  32  extended load data; 0 for stores and errors.
REQ-014 resp_err_o  output  1  request rejected; valid only with resp_valid_o.

Function
REQ-015 SHALL implement FSM IDLE, WAIT, RESP; req_ready_o = 1 only in IDLE.
REQ-016 Request SHALL be accepted on an edge where req_valid_i && req_ready_o; all request fields captured into registers at that edge.
REQ-017 On accept, SHALL go to RESP if WAIT_CYCLES = 0, else to WAIT with counter loaded to WAIT_CYCLES-1.
REQ-018 In WAIT, counter SHALL decrement each cycle; at count 0 next state SHALL be RESP.
REQ-019 In RESP, resp_valid_o SHALL be 1 for exactly one cycle; next state SHALL be IDLE unconditionally (no response backpressure).
REQ-020 Latency accept-edge to resp_valid_o high SHALL be exactly WAIT_CYCLES+1 cycles; back-to-back throughput one request per WAIT_CYCLES+2 cycles.
REQ-021 Error SHALL be flagged for: size 11; half with addr[0]=1; word with addr[1:0]!=0; any set bit in addr[31:ADDR_WIDTH].
REQ-022 Erroneous request SHALL NOT modify storage; response SHALL carry resp_err_o=1, resp_rdata_o=0.
REQ-023 Storage SHALL be 2^(ADDR_WIDTH-2) words, little-endian, byte lane = addr[1:0].
REQ-024 Store SHALL update only the addressed byte(s) (byte: 1 lane, half: lanes addr[1]*2..+1, word: all 4) on the edge entering RESP.
REQ-025 Load SHALL read storage on the edge entering RESP, select addressed lane(s), extend to 32 bits per req_unsigned_i; word loads ignore req_unsigned_i.
REQ-026 resp_rdata_o and resp_err_o SHALL be 0 whenever resp_valid_o = 0.
REQ-027 Inputs while not in IDLE SHALL be ignored.

Reset
REQ-028 rst_n low SHALL asynchronously force state IDLE, counter 0, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0; req_ready_o=1 after release.
REQ-029 Reset in WAIT or RESP SHALL discard the in-flight request; a store not yet committed (state WAIT) SHALL NOT be written.
REQ-030 Storage contents SHALL NOT be cleared by reset.

Verification
REQ-031 Word store 0xDEADBEEF @0x100, then word load @0x100 -> load resp_rdata_o=0xDEADBEEF, resp_err_o=0, resp_valid_o exactly 2 cycles after accept (WAIT_CYCLES=1).
REQ-032 After REQ-031, byte store 0x5A @0x102, then signed byte load @0x103 -> 0xFFFFFFDE; unsigned half load @0x102 -> 0x0000DE5A; word load @0x100 -> 0xDE5ABEEF.
REQ-033 Word load @0x102, half store @0x101, size 11 @0x0, word load @0x1000 -> each resp_err_o=1, resp_rdata_o=0; subsequent word load @0x100 unchanged.
REQ-034 req_valid_i held high continuously -> req_ready_o pulses once per 3 cycles, exactly one resp_valid_o per accepted request, no accepts in WAIT/RESP.
REQ-035 Word store 0x12345678 @0x200, rst_n asserted in WAIT -> outputs zero immediately, later load @0x200 returns prior contents (not 0x12345678).
REQ-036 Rebuild with WAIT_CYCLES=0 -> resp_valid_o high on cycle after accept, req_ready_o back high the following cycle.
